popcount_seq: RTL and testbench
===============================

// Module: popcount_seq
// PURPOSE
//   Parametrised sequential bit-count/logic-function unit. Accepts a WIDTH-bit vector over a
//   valid/ready handshake and counts its ones CHUNK bits per cycle. Returns the count plus a
//   1-bit result selected by mode: popcount-nonzero, parity, majority or threshold.
//   Shared evaluation engine for the gate/popcount exercises; replaces fixed 3-input gates.
// PARAMETERS
//   WIDTH   8   input vector width, >= 1
//   CHUNK   4   bits counted per cycle, 1..WIDTH; need not divide WIDTH
//   Derived: CW = $clog2(WIDTH+1) count width; NCHUNK = ceil(WIDTH/CHUNK)
// PORTS
//   CLK        in   1       clock, rising edge
//   RST_N      in   1       asynchronous active-low reset
//   IN_VALID   in   1       request valid
//   IN_READY   out  1       unit can accept a request
//   IN_DATA    in   WIDTH   vector to evaluate
//   IN_MODE    in   2       00 POP, 01 PARITY, 10 MAJORITY, 11 THRESH
//   IN_THRESH  in   CW      threshold, used only in THRESH mode
//   OUT_VALID  out  1       result valid
//   OUT_READY  in   1       consumer accepts result
//   OUT_COUNT  out  CW      number of ones in captured IN_DATA
//   OUT_Y      out  1       mode-selected result
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE, IN_READY=1, OUT_VALID=0, OUT_COUNT=0,
//     OUT_Y=0, chunk index 0, accumulator 0.
//   FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: IN_READY=1. On IN_VALID&IN_READY, capture IN_DATA, IN_MODE and IN_THRESH.
//     Clear the accumulator and index, then go to BUSY.
//   BUSY: IN_READY=0. Each cycle add the ones of chunk k = DATA[k*CHUNK +: CHUNK] to the
//     accumulator. Bits at or above WIDTH in the last chunk are masked to 0.
//     After chunk NCHUNK-1, latch OUT_COUNT and OUT_Y and go to DONE.
//   DONE: OUT_VALID=1, IN_READY=0. OUT_COUNT and OUT_Y stay stable until OUT_READY=1.
//     On OUT_VALID&OUT_READY, go to IDLE; OUT_VALID falls on that edge.
//   Latency: OUT_VALID rises NCHUNK cycles after the accept edge. Throughput is one request
//     per NCHUNK+2 cycles with OUT_READY tied high. There is no overlap between requests.
//   OUT_Y by captured mode:
//     POP      count != 0
//     PARITY   count[0] (XOR of all bits)
//     MAJORITY 2*count > WIDTH (strict; a tie gives 0)
//     THRESH   count >= IN_THRESH (THRESH=0 gives 1; THRESH>WIDTH gives 0)
//   Input changes while BUSY/DONE are ignored, because the captured copies are used.
//   IN_VALID in BUSY/DONE is not accepted and must be held by the sender.
//   Accumulator is CW bits wide and cannot overflow, since its maximum is WIDTH.
//   RST_N low mid-BUSY or mid-DONE: result discarded, outputs return to reset values at once.
//   WIDTH=1 or CHUNK=WIDTH gives NCHUNK=1, a single BUSY cycle.
// STRUCTURE
//   popcount_pkg: typedef enum logic[1:0] mode_e {POP, PARITY, MAJORITY, THRESH};
//     typedef enum state_e {IDLE, BUSY, DONE}.
//   Sub-module popcount_chunk #(CHUNK): combinational ones-count of CHUNK bits,
//     output $clog2(CHUNK+1) bits. Instantiate once; drive it with a masked, indexed slice.
//   Top holds FSM, capture registers, chunk index, accumulator and result-select logic.
// TESTING (default WIDTH=8, CHUNK=4 unless stated)
//   1 Reset asserted mid-run -> IN_READY=1, OUT_VALID=0, OUT_COUNT=0, OUT_Y=0 immediately.
//   2 POP, IN_DATA=8'hB5 -> OUT_VALID 2 cycles after accept; OUT_COUNT=5, OUT_Y=1.
//     POP, 8'h00 -> OUT_COUNT=0, OUT_Y=0.
//   3 PARITY 8'h07 -> count 3, Y=1. MAJORITY 8'h0F -> count 4, Y=0 (tie).
//     MAJORITY 8'h1F -> Y=1.
//   4 THRESH 8'hFF: THRESH=8 -> Y=1; THRESH=9 -> Y=0; THRESH=0 with 8'h00 -> Y=1.
//   5 Backpressure: OUT_READY=0 for 5 cycles in DONE -> outputs stable, IN_READY=0,
//     second IN_VALID not taken. Inputs changed mid-BUSY -> result unaffected.
//   6 WIDTH=3, CHUNK=1, all 8 vectors in all modes: latency 3. Vector 3'b011 gives
//     count 2, MAJORITY=1, PARITY=0. WIDTH=10, CHUNK=4, 10'h3FF: count 10, latency 3
//     (masking check).

Source files
------------

// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types and helpers for the sequential popcount unit
//
// Purpose: result-mode and FSM-state enumerations plus a constant helper used to
//          size the chunk loop of popcount_seq.
// Ports:   none (package).
package popcount_pkg;

  typedef enum logic [1:0] {
    POP      = 2'd0,
    PARITY   = 2'd1,
    MAJORITY = 2'd2,
    THRESH   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/popcount_seq_chunk.sv
// rtl/popcount_seq_chunk.sv - combinational ones-count of one CHUNK-bit slice
//
// Purpose: counts the set bits of a single chunk; the sequential top feeds it one
//          slice per cycle.
// Ports:   bits  in  CHUNK               slice to count (already masked)
//          ones  out $clog2(CHUNK+1)     number of set bits in the slice
module popcount_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0]               bits,
  output logic [$clog2(CHUNK+1)-1:0]     ones
);

  localparam int OW = $clog2(CHUNK + 1);

  always_comb begin
    ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      ones = ones + OW'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - sequential chunked popcount with mode-selected 1-bit result
//
// Purpose: accepts a WIDTH-bit vector over valid/ready, counts its ones CHUNK bits per
//          cycle, then presents the count and a POP/PARITY/MAJORITY/THRESH result
//          until the consumer takes it.
// Ports:   clk        in   1      rising-edge clock
//          rst_n      in   1      asynchronous active-low reset
//          in_valid   in   1      request valid
//          in_ready   out  1      unit idle and able to accept
//          in_data    in   WIDTH  vector to evaluate
//          in_mode    in   2      result mode (mode_e)
//          in_thresh  in   CW     threshold for THRESH mode
//          out_valid  out  1      result valid
//          out_ready  in   1      consumer accepts result
//          out_count  out  CW     ones in the captured vector
//          out_y      out  1      mode-selected result bit
module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CHUNK = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [CW-1:0]    in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_y
);

  localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CCW    = $clog2(CHUNK + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] data_q,   data_d;
  mode_e            mode_q,   mode_d;
  logic [CW-1:0]    thresh_q, thresh_d;
  logic [CW-1:0]    acc_q,    acc_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             y_q,      y_d;

  logic [PW-1:0]    data_pad;
  logic [CHUNK-1:0] chunk_bits;
  logic [CCW-1:0]   chunk_ones;
  logic [CW-1:0]    total;
  logic             total_y;

  // Zero-extending to a whole number of chunks masks the bits past WIDTH
  // in the final chunk.
  assign data_pad   = PW'(data_q);
  assign chunk_bits = data_pad[idx_q*CHUNK +: CHUNK];

  popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits (chunk_bits),
    .ones (chunk_ones)
  );

  // Running total including this cycle's chunk; on the last chunk it is the final count.
  assign total = acc_q + CW'(chunk_ones);

  always_comb begin
    total_y = 1'b0;
    case (mode_q)
      POP:      total_y = (total != '0);
      PARITY:   total_y = total[0];
      // One extra bit so 2*count cannot wrap.
      MAJORITY: total_y = ({1'b0, total} << 1) > (CW + 1)'(WIDTH);
      THRESH:   total_y = (total >= thresh_q);
      default:  total_y = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mode_q   <= POP;
      thresh_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      y_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      thresh_q <= thresh_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      y_q      <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)           state_d = BUSY;
      BUSY:    if (idx_q == LAST_IDX)  state_d = DONE;
      DONE:    if (out_ready)          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    count_d  = count_q;
    y_d      = y_q;
    if (state_q == IDLE && in_valid) begin
      data_d   = in_data;
      mode_d   = mode_e'(in_mode);
      thresh_d = in_thresh;
      acc_d    = '0;
      idx_d    = '0;
    end else if (state_q == BUSY) begin
      acc_d = total;
      idx_d = idx_q + IW'(1);
      if (idx_q == LAST_IDX) begin
        count_d = total;
        y_d     = total_y;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_count = count_q;
    out_y     = y_q;
  end

endmodule

// File: tb/tb_popcount_seq.sv
// tb/tb_popcount_seq.sv - self-checking bench for popcount_seq in three configurations
//
// Purpose: drives WIDTH/CHUNK = 8/4, 3/1 and 10/4 instances and compares counts,
//          result bits and latency against a bit-counting reference model.
// Ports:   none (top-level bench).
module tb_popcount_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_valid_v = '0;
  logic [9:0] data = '0;
  logic [1:0] mode = '0;
  logic [3:0] thresh = '0;
  logic       out_ready = 1'b0;
  logic [2:0] in_ready_v, out_valid_v, y_v;
  logic [3:0] cnt0, cnt2;
  logic [1:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  popcount_seq #(.WIDTH(8), .CHUNK(4)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(data[7:0]), .in_mode(mode), .in_thresh(thresh),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_count(cnt0), .out_y(y_v[0]));

  popcount_seq #(.WIDTH(3), .CHUNK(1)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(data[2:0]), .in_mode(mode), .in_thresh(thresh[1:0]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_count(cnt1), .out_y(y_v[1]));

  popcount_seq #(.WIDTH(10), .CHUNK(4)) dut_w10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(data), .in_mode(mode), .in_thresh(thresh),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_count(cnt2), .out_y(y_v[2]));

  function automatic int width_of(int d);
    return (d == 0) ? 8 : (d == 1) ? 3 : 10;
  endfunction

  function automatic int lat_of(int d);
    return (width_of(d) + ((d == 1) ? 1 : 4) - 1) / ((d == 1) ? 1 : 4);
  endfunction

  function automatic logic [3:0] get_cnt(int d);
    return (d == 0) ? cnt0 : (d == 1) ? {2'b00, cnt1} : cnt2;
  endfunction

  // Reference: count ones of the low w bits, then apply the mode rule arithmetically.
  function automatic logic [4:0] model(int w, logic [9:0] dat, logic [1:0] m, int th);
    int   c = 0;
    logic y;
    for (int i = 0; i < w; i++) c += int'(dat[i]);
    case (m)
      2'd0:    y = (c != 0);
      2'd1:    y = (c % 2) == 1;
      2'd2:    y = (2 * c) > w;
      default: y = (c >= th);
    endcase
    return {4'(c), y};
  endfunction

  task automatic start(int d, logic [9:0] dat, logic [1:0] m, logic [3:0] th);
    @(negedge clk);
    data = dat; mode = m; thresh = th;
    in_valid_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
  endtask

  task automatic wait_valid(int d, output int lat);
    lat = 0;
    while (out_valid_v[d] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic xact(int d, logic [9:0] dat, logic [1:0] m, logic [3:0] th,
                      output logic [3:0] c, output logic y, output int lat,
                      output logic idle_ok);
    start(d, dat, m, th);
    wait_valid(d, lat);
    c = get_cnt(d);
    y = y_v[d];
    release_out();
    idle_ok = (out_valid_v[d] === 1'b0) && (in_ready_v[d] === 1'b1);
  endtask

  task automatic test_reset();
    int lat;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready_v[0], out_valid_v[0], cnt0, y_v[0]} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_hold: got rdy=%b vld=%b cnt=%0d y=%b want 1 0 0 0",
               in_ready_v[0], out_valid_v[0], cnt0, y_v[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // Mid-DONE reset: a held result (8, 1) must vanish at once.
    start(0, 10'h0FF, 2'd0, 4'd0);
    wait_valid(0, lat);
    n_checks++;
    if (cnt0 !== 4'd8 || lat != 2) begin
      n_fail++;
      $display("FAIL reset_pre_done: got cnt=%0d lat=%0d want cnt=8 lat=2", cnt0, lat);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready_v[0], out_valid_v[0], cnt0, y_v[0]} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_mid_done: got rdy=%b vld=%b cnt=%0d y=%b want 1 0 0 0",
               in_ready_v[0], out_valid_v[0], cnt0, y_v[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    // Mid-BUSY reset: unit must be ready immediately and never produce the result.
    start(0, 10'h0B5, 2'd0, 4'd0);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready_v[0], out_valid_v[0], cnt0, y_v[0]} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got rdy=%b vld=%b cnt=%0d y=%b want 1 0 0 0",
               in_ready_v[0], out_valid_v[0], cnt0, y_v[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard: got vld=%b rdy=%b want vld=0 rdy=1",
               out_valid_v[0], in_ready_v[0]);
    end
  endtask

  task automatic test_directed();
    logic [7:0] td [8] = '{8'hB5, 8'h00, 8'h07, 8'h0F, 8'h1F, 8'hFF, 8'hFF, 8'h00};
    logic [1:0] tm [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [3:0] tt [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd9, 4'd0};
    logic [3:0] ec [8] = '{4'd5, 4'd0, 4'd3, 4'd4, 4'd5, 4'd8, 4'd8, 4'd0};
    logic       ey [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] c;
    logic       y, ok;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      xact(0, {2'b00, td[i]}, tm[i], tt[i], c, y, lat, ok);
      n_checks++;
      if (c !== ec[i] || y !== ey[i] || lat != 2 || !ok) begin
        n_fail++;
        $display("FAIL directed[%0d]: got cnt=%0d y=%b lat=%0d idle=%b want cnt=%0d y=%b lat=2 idle=1",
                 i, c, y, lat, ok, ec[i], ey[i]);
      end
    end
  endtask

  task automatic test_random(int d, int n);
    logic [9:0] dat;
    logic [1:0] m;
    logic [3:0] th, c;
    logic [4:0] exp;
    logic       y, ok;
    int         lat;
    for (int i = 0; i < n; i++) begin
      dat = 10'($urandom);
      m   = 2'($urandom);
      th  = 4'($urandom_range(0, (d == 1) ? 3 : 15));
      xact(d, dat, m, th, c, y, lat, ok);
      exp = model(width_of(d), dat, m, int'(th));
      n_checks++;
      if ({c, y} !== exp || lat != lat_of(d) || !ok) begin
        n_fail++;
        $display("FAIL random_d%0d: data=%h mode=%0d th=%0d got cnt=%0d y=%b lat=%0d idle=%b want cnt=%0d y=%b lat=%0d",
                 d, dat, m, th, c, y, lat, ok, exp[4:1], exp[0], lat_of(d));
      end
    end
  endtask

  task automatic test_busy_change();
    int lat;
    start(0, 10'h0B5, 2'd0, 4'd0);
    data = 10'h000; mode = 2'd3; thresh = 4'd15;
    wait_valid(0, lat);
    n_checks++;
    if (cnt0 !== 4'd5 || y_v[0] !== 1'b1 || lat != 2) begin
      n_fail++;
      $display("FAIL busy_change: got cnt=%0d y=%b lat=%0d want cnt=5 y=1 lat=2", cnt0, y_v[0], lat);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    start(0, 10'h00E, 2'd1, 4'd0);
    wait_valid(0, lat);
    data = 10'h0FF; mode = 2'd0; in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || cnt0 !== 4'd3 || y_v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got vld=%b rdy=%b cnt=%0d y=%b want 1 0 3 1",
                 i, out_valid_v[0], in_ready_v[0], cnt0, y_v[0]);
      end
    end
    in_valid_v[0] = 1'b0;
    release_out();
    n_checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b want 0 1", out_valid_v[0], in_ready_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int waited;
    data = 10'h0B5; mode = 2'd0; out_ready = 1'b1; in_valid_v[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready_v[0] === 1'b1) acc.push_back(c);
    end
    in_valid_v[0] = 1'b0;
    waited = 0;
    while (in_ready_v[0] !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (acc.size() < 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d accepts want >= 4", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] != 4) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles want 4", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_w3_exhaustive();
    logic [3:0] c, th;
    logic [4:0] exp;
    logic       y, ok;
    int         lat;
    for (int v = 0; v < 8; v++) begin
      for (int m = 0; m < 4; m++) begin
        th = 4'($urandom_range(0, 3));
        xact(1, 10'(v), 2'(m), th, c, y, lat, ok);
        exp = model(3, 10'(v), 2'(m), int'(th));
        n_checks++;
        if ({c, y} !== exp || lat != 3 || !ok) begin
          n_fail++;
          $display("FAIL w3[v=%0d m=%0d th=%0d]: got cnt=%0d y=%b lat=%0d idle=%b want cnt=%0d y=%b lat=3",
                   v, m, th, c, y, lat, ok, exp[4:1], exp[0]);
        end
      end
    end
    xact(1, 10'h003, 2'd2, 4'd0, c, y, lat, ok);
    n_checks++;
    if (c !== 4'd2 || y !== 1'b1) begin
      n_fail++;
      $display("FAIL w3_011_majority: got cnt=%0d y=%b want cnt=2 y=1", c, y);
    end
    xact(1, 10'h003, 2'd1, 4'd0, c, y, lat, ok);
    n_checks++;
    if (c !== 4'd2 || y !== 1'b0) begin
      n_fail++;
      $display("FAIL w3_011_parity: got cnt=%0d y=%b want cnt=2 y=0", c, y);
    end
  endtask

  task automatic test_w10_mask();
    logic [3:0] c;
    logic       y, ok;
    int         lat;
    xact(2, 10'h3FF, 2'd0, 4'd0, c, y, lat, ok);
    n_checks++;
    if (c !== 4'd10 || y !== 1'b1 || lat != 3 || !ok) begin
      n_fail++;
      $display("FAIL w10_all_ones: got cnt=%0d y=%b lat=%0d idle=%b want cnt=10 y=1 lat=3 idle=1",
               c, y, lat, ok);
    end
    xact(2, 10'h3FF, 2'd2, 4'd0, c, y, lat, ok);
    n_checks++;
    if (c !== 4'd10 || y !== 1'b1) begin
      n_fail++;
      $display("FAIL w10_majority: got cnt=%0d y=%b want cnt=10 y=1", c, y);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(0, 40);
    test_busy_change();
    test_backpressure();
    test_back_to_back();
    test_w3_exhaustive();
    test_w10_mask();
    test_random(2, 25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
